// File: rtl/arith_pkg.sv
// Shared arithmetic types: sequencer states and digit-counter sizing.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter must hold 0..WIDTH/BPC inclusive.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

endpackage

// File: rtl/fsc_cell.sv
// One-bit full-subtractor cell: z = x - y - bi, borrow out on bo.
// Purely combinational, no latency, no backpressure.
module fsc_cell (
  input  logic bi,
  input  logic x,
  input  logic y,
  output logic z,
  output logic bo
);

  assign z  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial X - Y - bin, BPC bits per clock; done WIDTH/BPC+1 cycles after start.
// Backpressure: start is taken only while ready; results hold until the next accepted start.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bo,
  output logic             zero,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / BPC;
  localparam int CNT_W = cnt_width(WIDTH, BPC);

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
    $fatal(1, "serial_subtractor: WIDTH must be >= 2 and divisible by BPC");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] diff_sh;
  logic [WIDTH-1:0] diff_nxt;
  logic [WIDTH-1:0] z_ext;
  logic [BPC-1:0]   z;
  logic [BPC:0]     b;
  logic             brw_q;
  logic             x_msb;
  logic             y_msb;
  logic             bo_q;
  logic             zero_q;
  logic             ovf_q;
  logic             last_dig;

  // Borrow ripples LSB cell first within the cycle; the FF links digits.
  assign b[0] = brw_q;

  for (genvar i = 0; i < BPC; i++) begin : g_cell
    fsc_cell u_cell (
      .bi (b[i]),
      .x  (x_sh[i]),
      .y  (y_sh[i]),
      .z  (z[i]),
      .bo (b[i+1])
    );
  end

  assign z_ext    = WIDTH'(z);
  assign diff_nxt = (diff_sh >> BPC) | (z_ext << (WIDTH - BPC));
  assign last_dig = (cnt == CNT_W'(NDIG - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      x_sh    <= '0;
      y_sh    <= '0;
      diff_sh <= '0;
      brw_q   <= 1'b0;
      x_msb   <= 1'b0;
      y_msb   <= 1'b0;
      bo_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state != RUN) begin
      if (start) begin
        x_sh  <= x;
        y_sh  <= y;
        brw_q <= bin;
        cnt   <= '0;
        x_msb <= x[WIDTH-1];
        y_msb <= y[WIDTH-1];
      end
    end else begin
      x_sh    <= x_sh >> BPC;
      y_sh    <= y_sh >> BPC;
      diff_sh <= diff_nxt;
      brw_q   <= b[BPC];
      cnt     <= cnt + 1'b1;
      // Flags are frozen on the final digit so they hold through DONE and IDLE.
      if (last_dig) begin
        bo_q   <= b[BPC];
        zero_q <= (diff_nxt == '0);
        ovf_q  <= (x_msb != y_msb) && (diff_nxt[WIDTH-1] != x_msb);
      end
    end
  end

  assign diff = diff_sh;
  assign bo   = bo_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: three configurations (8/1, 8/4, 4/2) share stimulus and
// are compared every cycle against an arithmetic model of x - y - bin.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       bin = 1'b0;
  logic [7:0] x8 = 8'h00;
  logic [7:0] y8 = 8'h00;

  logic [2:0] rdy, bsy, dn, bo_o, zr, ov;
  logic [7:0] d_a, d_b;
  logic [3:0] d_c;

  int n_pass = 0;
  int n_checks = 0;

  int   cyc = 0;
  bit   armed = 1'b0;
  bit   rst_edge = 1'b0;
  bit   rdy_s [3] = '{1'b0, 1'b0, 1'b0};
  bit   pv [3] = '{1'b0, 1'b0, 1'b0};
  int   due [3] = '{0, 0, 0};
  logic [10:0] exp_r [3];
  int   wid [3] = '{8, 8, 4};
  int   ndig [3] = '{8, 2, 2};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BPC(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .x(x8), .y(y8),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .diff(d_a),
    .bo(bo_o[0]), .zero(zr[0]), .ovf(ov[0]));

  serial_subtractor #(.WIDTH(8), .BPC(4)) u_b (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .x(x8), .y(y8),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .diff(d_b),
    .bo(bo_o[1]), .zero(zr[1]), .ovf(ov[1]));

  serial_subtractor #(.WIDTH(4), .BPC(2)) u_c (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .x(x8[3:0]), .y(y8[3:0]),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .diff(d_c),
    .bo(bo_o[2]), .zero(zr[2]), .ovf(ov[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  function automatic logic [7:0] dout(input int d);
    if (d == 0) return d_a;
    if (d == 1) return d_b;
    return {4'h0, d_c};
  endfunction

  // Result packed as {ovf, zero, bo, diff[7:0]}, from plain integer arithmetic.
  function automatic logic [10:0] model(input int w, input int xv, input int yv, input int b);
    int m, d, dm, sx, sy, sd;
    logic ov_e;
    m    = 1 << w;
    d    = xv - yv - b;
    dm   = (d + m) % m;
    sx   = (xv >= m / 2) ? xv - m : xv;
    sy   = (yv >= m / 2) ? yv - m : yv;
    sd   = sx - sy - b;
    ov_e = (sd < -(m / 2)) || (sd >= m / 2);
    return {ov_e, (dm == 0), (d < 0), 8'(dm)};
  endfunction

  // Acceptance tracking: inputs as presented at the edge, ready as seen before it.
  always @(posedge clk) begin
    rst_edge = rst;
    if (rst) armed = 1'b1;
    for (int d = 0; d < 3; d++) begin
      if (rst) pv[d] = 1'b0;
      else if (armed && start && rdy_s[d]) begin
        pv[d]    = 1'b1;
        due[d]   = cyc + ndig[d] + 1;
        exp_r[d] = model(wid[d], int'(x8) & ((1 << wid[d]) - 1),
                         int'(y8) & ((1 << wid[d]) - 1), int'(bin));
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        bit eb, ed;
        rdy_s[d] = rdy[d];
        if (rst_edge) begin
          chk("reset_state", 32'({rdy[d], bsy[d], dn[d], ov[d], zr[d], bo_o[d], dout(d)}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
        end else begin
          eb = pv[d] && (cyc < due[d]);
          ed = pv[d] && (cyc == due[d]);
          chk("busy", 32'(bsy[d]), 32'(eb));
          chk("ready", 32'(rdy[d]), 32'(!eb));
          chk("done", 32'(dn[d]), 32'(ed));
          if (dn[d] && ed)
            chk("result", 32'({ov[d], zr[d], bo_o[d], dout(d)}), 32'(exp_r[d]));
        end
      end
    end
  end

  task automatic do_op(input logic [7:0] xa, input logic [7:0] ya, input logic ba,
                       output int lat, output int nbusy, output logic [10:0] res);
    @(posedge clk); #1;
    x8 = xa; y8 = ya; bin = ba; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bsy[0]) nbusy++;
      if (dn[0]) begin
        lat = i;
        break;
      end
    end
    res = {ov[0], zr[0], bo_o[0], d_a};
  endtask

  task automatic step_op(input logic [7:0] xa, input logic [7:0] ya, input logic ba);
    @(posedge clk); #1;
    x8 = xa; y8 = ya; bin = ba; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    int lat, nb, ndone;
    logic [10:0] res;
    logic [10:0] first_res;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_op(8'h05, 8'h03, 1'b0, lat, nb, res);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(nb), 32'd8);
    chk("t1_result", 32'(res), 32'h002);
    @(negedge clk);
    chk("t1_hold", 32'({rdy[0], d_a}), 32'h102);

    do_op(8'h03, 8'h05, 1'b0, lat, nb, res);
    chk("t2_neg", 32'(res), 32'h1FE);
    do_op(8'h2A, 8'h2A, 1'b0, lat, nb, res);
    chk("t2_zero", 32'(res), 32'h200);
    do_op(8'h00, 8'h00, 1'b1, lat, nb, res);
    chk("t2_bin", 32'(res), 32'h1FF);
    do_op(8'h80, 8'h01, 1'b0, lat, nb, res);
    chk("t3_ovf_neg", 32'(res), 32'h47F);
    do_op(8'h7F, 8'hFF, 1'b0, lat, nb, res);
    chk("t3_ovf_pos", 32'(res), 32'h580);

    // Start pulsed mid-RUN must be ignored by the 8/1 unit.
    @(posedge clk); #1;
    x8 = 8'h10; y8 = 8'h04; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    x8 = 8'hF0; y8 = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    first_res = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        ndone++;
        if (ndone == 1) first_res = {ov[0], zr[0], bo_o[0], d_a};
      end
    end
    chk("t4_one_done", 32'(ndone), 32'd1);
    chk("t4_first_op", 32'(first_res), 32'h00C);

    // Back-to-back: new start raised during the DONE cycle.
    do_op(8'h33, 8'h11, 1'b0, lat, nb, res);
    chk("t4_pre_b2b", 32'(res), 32'h022);
    x8 = 8'h01; y8 = 8'h02; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dn[0]) begin
        lat = i;
        break;
      end
    end
    chk("t4_b2b_latency", 32'(lat), 32'd9);
    chk("t4_b2b_result", 32'({ov[0], zr[0], bo_o[0], d_a}), 32'h1FE);

    // Reset during RUN cycle 4.
    @(posedge clk); #1;
    x8 = 8'h55; y8 = 8'h22; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_abort", 32'({rdy[0], bsy[0], d_a}), 32'h200);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn[0]) ndone++;
    end
    chk("t5_no_done", 32'(ndone), 32'd0);

    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; x8 = 8'h09; y8 = 8'h01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t5_rst_wins", 32'({rdy[0], bsy[0], rdy[1], bsy[1]}), 32'b1010);

    // Exhaustive over the 4-bit unit's operand space.
    for (int xv = 0; xv < 16; xv++)
      for (int yv = 0; yv < 16; yv++)
        for (int b = 0; b < 2; b++)
          step_op({4'($urandom), 4'(xv)}, {4'($urandom), 4'(yv)}, 1'(b));

    // Random operands with random spacing for the 8-bit units.
    for (int i = 0; i < 3000; i++) begin
      step_op(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (12) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
